// File: rtl/alarm_pkg.sv
// Shared types, default phase lengths and helpers for the front-gate alarm controller.
package alarm_pkg;

   typedef enum logic [2:0] {
      DISARMED,
      ARMED,
      ENTRY,
      ALARM,
      REARM
   } state_t;

   localparam int DEF_ENTRY_CYC = 8;
   localparam int DEF_ALARM_CYC = 16;
   localparam int DEF_REARM_CYC = 4;
   localparam int DEF_FM_W      = 8;
   localparam int DEF_TRIP_W    = 4;

   // Increment that sticks at max_value instead of wrapping.
   function automatic int unsigned sat_inc(input int unsigned value,
                                           input int unsigned max_value);
      return (value >= max_value) ? max_value : value + 1;
   endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter holding the remaining cycles of the current timed phase.
module alarm_timer #(
   parameter int FM_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [FM_W-1:0] load_val,
   input  logic            en,
   output logic [FM_W-1:0] cnt,
   output logic            last
);

   // Load wins over decrement; the count parks at zero rather than wrapping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - FM_W'(1);
      end
   end

   assign last = (cnt == FM_W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Front-gate alarm: arms, runs an entry delay on a gate trip, sounds a timed siren,
// and supports disarm and exit-delay rearm.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int ENTRY_CYC = DEF_ENTRY_CYC,
   parameter int ALARM_CYC = DEF_ALARM_CYC,
   parameter int REARM_CYC = DEF_REARM_CYC,
   parameter int FM_W      = DEF_FM_W,
   parameter int TRIP_W    = DEF_TRIP_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frontgate_t,
   input  logic              request_t,
   input  logic              arm_req,
   output logic              alarm,
   output logic              armed,
   output logic [FM_W-1:0]   fm,
   output logic [TRIP_W-1:0] trip_cnt
);

   localparam int unsigned TRIP_MAX = (1 << TRIP_W) - 1;

   state_t          state;
   logic            fg_q;
   logic            trip;
   logic            tmr_load;
   logic [FM_W-1:0] tmr_val;
   logic            tmr_en;
   logic            fm_last;

   // fg_q resets high so a gate already open at reset release is not a trip.
   assign trip = frontgate_t & ~fg_q;

   alarm_timer #(
      .FM_W(FM_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .cnt      (fm),
      .last     (fm_last)
   );

   // Timer control mirrors the state transitions below: load on phase entry,
   // load zero on any exit, otherwise count down while in a timed phase.
   always_comb begin
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
      case (state)
         ARMED: begin
            if (!request_t && trip) begin
               tmr_load = 1'b1;
               tmr_val  = FM_W'(ENTRY_CYC);
            end
         end
         ENTRY: begin
            if (request_t) begin
               tmr_load = 1'b1;
            end else if (fm_last) begin
               tmr_load = 1'b1;
               tmr_val  = FM_W'(ALARM_CYC);
            end else begin
               tmr_en = 1'b1;
            end
         end
         ALARM, REARM: begin
            if (request_t || fm_last) begin
               tmr_load = 1'b1;
            end else begin
               tmr_en = 1'b1;
            end
         end
         DISARMED: begin
            if (arm_req) begin
               tmr_load = 1'b1;
               tmr_val  = FM_W'(REARM_CYC);
            end
         end
         default: begin
            tmr_load = 1'b1;
         end
      endcase
   end

   // Main FSM; alarm and armed are registered alongside the state so they
   // change on the same edge as the transition that implies them.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ARMED;
         alarm    <= 1'b0;
         armed    <= 1'b1;
         trip_cnt <= '0;
         fg_q     <= 1'b1;
      end else begin
         fg_q <= frontgate_t;
         case (state)
            ARMED: begin
               if (request_t) begin
                  state <= DISARMED;
                  armed <= 1'b0;
               end else if (trip) begin
                  state <= ENTRY;
               end
            end
            ENTRY: begin
               if (request_t) begin
                  state <= DISARMED;
                  armed <= 1'b0;
               end else if (fm_last) begin
                  state    <= ALARM;
                  alarm    <= 1'b1;
                  trip_cnt <= TRIP_W'(sat_inc(32'(trip_cnt), TRIP_MAX));
               end
            end
            ALARM: begin
               if (request_t) begin
                  state <= DISARMED;
                  alarm <= 1'b0;
                  armed <= 1'b0;
               end else if (fm_last) begin
                  state <= ARMED;
                  alarm <= 1'b0;
               end
            end
            DISARMED: begin
               if (arm_req) begin
                  state <= REARM;
               end
            end
            REARM: begin
               if (request_t) begin
                  state <= DISARMED;
               end else if (fm_last) begin
                  state <= ARMED;
                  armed <= 1'b1;
               end
            end
            default: begin
               state <= ARMED;
               alarm <= 1'b0;
               armed <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed vector table, corner sequences and
// randomized stimulus against a deadline-based reference model.
module tb_alarm_ctrl;

   localparam int ENTRY_CYC = 8;
   localparam int ALARM_CYC = 16;
   localparam int REARM_CYC = 4;
   localparam int FM_W      = 8;
   localparam int TRIP_W    = 4;
   localparam int TRIP_MAX  = 15;

   logic              clk;
   logic              reset;
   logic              frontgate_t;
   logic              request_t;
   logic              arm_req;
   logic              alarm;
   logic              armed;
   logic [FM_W-1:0]   fm;
   logic [TRIP_W-1:0] trip_cnt;

   int checks;
   int errors;

   alarm_ctrl #(
      .ENTRY_CYC (ENTRY_CYC),
      .ALARM_CYC (ALARM_CYC),
      .REARM_CYC (REARM_CYC),
      .FM_W      (FM_W),
      .TRIP_W    (TRIP_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .frontgate_t (frontgate_t),
      .request_t   (request_t),
      .arm_req     (arm_req),
      .alarm       (alarm),
      .armed       (armed),
      .fm          (fm),
      .trip_cnt    (trip_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: the phase is tracked by name plus the absolute cycle at
   // which it ends; the countdown is simply the distance to that deadline.
   typedef enum int {M_DIS, M_ARMED, M_ENTRY, M_ALARM, M_REARM} mode_t;
   mode_t m_mode;
   int    m_n;
   int    m_end;
   logic  m_prev_fg;
   int    m_trips;

   function automatic void model_reset();
      m_mode    = M_ARMED;
      m_prev_fg = 1'b1;
      m_trips   = 0;
      m_end     = m_n;
   endfunction

   function automatic void model_step(input logic r, input logic fg,
                                      input logic rq, input logic am);
      logic trip;
      m_n++;
      if (r) begin
         model_reset();
         return;
      end
      trip      = fg && !m_prev_fg;
      m_prev_fg = fg;
      case (m_mode)
         M_ARMED: begin
            if (rq) m_mode = M_DIS;
            else if (trip) begin
               m_mode = M_ENTRY;
               m_end  = m_n + ENTRY_CYC;
            end
         end
         M_ENTRY: begin
            if (rq) m_mode = M_DIS;
            else if (m_n == m_end) begin
               m_mode = M_ALARM;
               m_end  = m_n + ALARM_CYC;
               if (m_trips < TRIP_MAX) m_trips++;
            end
         end
         M_ALARM: begin
            if (rq) m_mode = M_DIS;
            else if (m_n == m_end) m_mode = M_ARMED;
         end
         M_DIS: begin
            if (am) begin
               m_mode = M_REARM;
               m_end  = m_n + REARM_CYC;
            end
         end
         M_REARM: begin
            if (rq) m_mode = M_DIS;
            else if (m_n == m_end) m_mode = M_ARMED;
         end
         default: m_mode = M_ARMED;
      endcase
   endfunction

   function automatic int model_fm();
      if (m_mode == M_ENTRY || m_mode == M_ALARM || m_mode == M_REARM) return m_end - m_n;
      return 0;
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
      end
   endtask

   task automatic check_output(input string tag);
      check({tag, ".alarm"},    int'(alarm),    (m_mode == M_ALARM) ? 1 : 0);
      check({tag, ".armed"},    int'(armed),
            (m_mode == M_ARMED || m_mode == M_ENTRY || m_mode == M_ALARM) ? 1 : 0);
      check({tag, ".fm"},       int'(fm),       model_fm());
      check({tag, ".trip_cnt"}, int'(trip_cnt), m_trips);
   endtask

   // Drive one cycle of inputs, let the edge happen, then sample 1 ns later.
   task automatic apply_stimulus(input logic r, input logic fg,
                                 input logic rq, input logic am);
      reset       = r;
      frontgate_t = fg;
      request_t   = rq;
      arm_req     = am;
      @(posedge clk);
      model_step(r, fg, rq, am);
      #1;
   endtask

   typedef struct {
      logic fg;
      logic req;
      logic arm;
      int   e_alarm;
      int   e_armed;
      int   e_fm;
      int   e_trip;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic fg, input logic rq, input logic am,
                                   input int ea, input int er, input int ef, input int et);
      vec_t v;
      v.fg = fg; v.req = rq; v.arm = am;
      v.e_alarm = ea; v.e_armed = er; v.e_fm = ef; v.e_trip = et;
      vecs.push_back(v);
   endfunction

   initial begin
      logic fg_r;
      checks      = 0;
      errors      = 0;
      m_n         = 0;
      reset       = 1'b1;
      frontgate_t = 1'b1;
      request_t   = 1'b0;
      arm_req     = 1'b0;
      model_reset();

      // Gate open through reset release, then trip/siren, same-cycle disarm,
      // rearm, entry abort, ignored trip in DISARMED, request beating arm_req.
      for (int i = 0; i < 20; i++) add_vec(1, 0, 0, 0, 1, 0, 0);
      add_vec(0, 0, 0, 0, 1, 0, 0);
      add_vec(1, 0, 0, 0, 1, ENTRY_CYC, 0);
      for (int k = ENTRY_CYC - 1; k >= 1; k--) add_vec(1, 0, 0, 0, 1, k, 0);
      add_vec(1, 0, 0, 1, 1, ALARM_CYC, 1);
      for (int k = ALARM_CYC - 1; k >= 1; k--) add_vec(1, 0, 0, 1, 1, k, 1);
      add_vec(1, 0, 0, 0, 1, 0, 1);
      add_vec(0, 0, 0, 0, 1, 0, 1);
      add_vec(1, 1, 0, 0, 0, 0, 1);
      add_vec(0, 0, 1, 0, 0, REARM_CYC, 1);
      for (int k = REARM_CYC - 1; k >= 1; k--) add_vec(0, 0, 0, 0, 0, k, 1);
      add_vec(0, 0, 0, 0, 1, 0, 1);
      add_vec(1, 0, 0, 0, 1, ENTRY_CYC, 1);
      add_vec(1, 0, 0, 0, 1, ENTRY_CYC - 1, 1);
      add_vec(1, 0, 0, 0, 1, ENTRY_CYC - 2, 1);
      add_vec(1, 1, 0, 0, 0, 0, 1);
      add_vec(0, 0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 0, 0, 0, 0, 1);
      add_vec(1, 0, 1, 0, 0, REARM_CYC, 1);
      add_vec(1, 0, 0, 0, 0, REARM_CYC - 1, 1);
      add_vec(1, 1, 1, 0, 0, 0, 1);

      apply_stimulus(1, 1, 0, 0);
      check("reset.alarm", int'(alarm), 0);
      check("reset.armed", int'(armed), 1);
      check("reset.fm", int'(fm), 0);
      check("reset.trip_cnt", int'(trip_cnt), 0);

      foreach (vecs[i]) begin
         apply_stimulus(0, vecs[i].fg, vecs[i].req, vecs[i].arm);
         check($sformatf("vec%0d.alarm", i), int'(alarm), vecs[i].e_alarm);
         check($sformatf("vec%0d.armed", i), int'(armed), vecs[i].e_armed);
         check($sformatf("vec%0d.fm", i), int'(fm), vecs[i].e_fm);
         check($sformatf("vec%0d.trip_cnt", i), int'(trip_cnt), vecs[i].e_trip);
      end

      // Rearm, then run 20 complete alarm cycles to reach saturation.
      apply_stimulus(0, 0, 0, 1);
      for (int i = 0; i < REARM_CYC; i++) apply_stimulus(0, 0, 0, 0);
      check_output("rearm_done");
      for (int c = 0; c < 20; c++) begin
         apply_stimulus(0, 0, 0, 0);
         for (int i = 0; i < ENTRY_CYC + ALARM_CYC + 1; i++) apply_stimulus(0, 1, 0, 0);
         check_output($sformatf("sat_cycle%0d", c));
      end
      check("sat.trip_cnt", int'(trip_cnt), TRIP_MAX);

      // Async reset in the middle of the siren, sampled before the next edge.
      apply_stimulus(0, 0, 0, 0);
      for (int i = 0; i < ENTRY_CYC + 3; i++) apply_stimulus(0, 1, 0, 0);
      check("mid_alarm.alarm", int'(alarm), 1);
      #1 reset = 1'b1;
      #1;
      check("async.alarm", int'(alarm), 0);
      check("async.fm", int'(fm), 0);
      check("async.armed", int'(armed), 1);
      check("async.trip_cnt", int'(trip_cnt), 0);
      apply_stimulus(1, 1, 0, 0);
      check_output("async_hold");

      // Randomized run against the model.
      fg_r = 1'b1;
      for (int i = 0; i < 500; i++) begin
         logic r, rq, am;
         if ($urandom_range(3) == 0) fg_r = ~fg_r;
         r  = ($urandom_range(63) == 0);
         rq = ($urandom_range(11) == 0);
         am = ($urandom_range(3) == 0);
         apply_stimulus(r, fg_r, rq, am);
         check_output($sformatf("rand%0d", i));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
